// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg -- shared types and defaults for the FIFO sequencing controller.
//   state_t          : controller FSM state, 2-bit encoded (IDLE=0, PRIME=1, RUN=2, DRAIN=3)
//   DEF_DEPTH/HI/LO  : default FIFO capacity and hysteresis watermarks
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_HI_WM = 12;
  localparam int DEF_LO_WM = 4;

endpackage

// File: rtl/fifo_sched_sat_cnt.sv
// sat_cnt -- enable-gated up-counter that sticks at all-ones instead of wrapping.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   en_i   : count this cycle
//   cnt_o  : current count
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_sched.sv
// fifo_sched -- sequences generator -> FIFO -> consumer. Converts raw enables
// into registered FIFO write/read strobes, tracks committed occupancy so the
// FIFO never over/underflows, and applies watermark hysteresis so reading only
// starts once the FIFO is primed.
//   CLK, RST   : clock (rising edge) and asynchronous active-low reset
//   Enwrk      : global work enable; low forces IDLE
//   ENgen      : generator wants to write
//   ENraf      : consumer wants to read
//   wrreq/rdreq: registered FIFO strobes
//   level      : occupancy including the strobes currently on the outputs
//   state      : FSM state code
//   stall_cnt  : saturating count of write-wanted-but-full cycles
//   rd_total   : wrapping count of issued reads
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int HI_WM = DEF_HI_WM,
  parameter int LO_WM = DEF_LO_WM,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Enwrk,
  input  logic          ENgen,
  input  logic          ENraf,
  output logic          wrreq,
  output logic          rdreq,
  output logic [LW-1:0] level,
  output logic [1:0]    state,
  output logic [7:0]    stall_cnt,
  output logic [15:0]   rd_total
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] HI_L    = LW'(HI_WM);
  localparam logic [LW-1:0] LO_L    = LW'(LO_WM);

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          wrreq_q, rdreq_q;
  logic          wr_d, rd_d;
  logic          stall_en;
  logic [15:0]   rd_total_q;

  // All decisions use the registered state and level, which is why PRIME
  // issues one extra write on the edge it hands over to RUN.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    wr_d     = Enwrk && ENgen && ((state_q == PRIME) || (state_q == RUN)) && (level_q < DEPTH_L);
    rd_d     = Enwrk && ENraf && ((state_q == RUN) || (state_q == DRAIN)) && (level_q != '0);
    stall_en = Enwrk && ENgen && ((state_q == PRIME) || (state_q == RUN)) && (level_q == DEPTH_L);
    level_d  = level_q + LW'(wr_d) - LW'(rd_d);

    if (!Enwrk) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ENgen)                          state_d = PRIME;
          else if (ENraf && level_q != '0)    state_d = DRAIN;
        end
        PRIME: begin
          if (level_q >= HI_L && ENraf)                 state_d = RUN;
          else if (!ENgen && ENraf && level_q != '0)    state_d = DRAIN;
          else if (!ENgen && !ENraf)                    state_d = IDLE;
        end
        RUN: begin
          if (!ENgen && ENraf)                state_d = DRAIN;
          else if (!ENgen && !ENraf)          state_d = IDLE;
          else if (level_q <= LO_L && ENgen)  state_d = PRIME;
        end
        DRAIN: begin
          if (ENgen)                          state_d = PRIME;
          else if (!ENraf || level_q == '0)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      level_q    <= '0;
      wrreq_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      rd_total_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wrreq_q    <= wr_d;
      rdreq_q    <= rd_d;
      rd_total_q <= rd_total_q + 16'(rd_d);
    end
  end

  sat_cnt #(.W(8)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  assign wrreq    = wrreq_q;
  assign rdreq    = rdreq_q;
  assign level    = level_q;
  assign state    = state_q;
  assign rd_total = rd_total_q;

endmodule

// File: doc/fifo_sched.md
# fifo_sched

Controller that sequences the generator → FIFO → consumer datapath of the course project. It turns the raw enables (Enwrk, ENgen, ENraf) into registered wrreq/rdreq strobes for a DEPTH-entry FIFO. It keeps its own occupancy count, so the FIFO can never overflow or underflow. It applies watermark hysteresis so the consumer only starts after the FIFO is primed, and it exports level, state and statistics for the 7-segment display path.

## Interface
Parameters:
- DEPTH, 16, FIFO capacity in entries
- HI_WM, 12, occupancy at which reading is allowed to start; LO_WM < HI_WM <= DEPTH
- LO_WM, 4, occupancy at which reading pauses for refill
- LW, $clog2(DEPTH+1), width of level

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-low (0 = reset)
- Enwrk  in  1  global work enable
- ENgen  in  1  generator has data / wants to write
- ENraf  in  1  consumer wants to read
- wrreq  out  1  registered FIFO write strobe
- rdreq  out  1  registered FIFO read strobe
- level  out  LW  committed occupancy (includes strobes currently on the outputs)
- state  out  2  FSM state code: IDLE=0, PRIME=1, RUN=2, DRAIN=3
- stall_cnt  out  8  saturating count of cycles with a write wanted but blocked by full
- rd_total  out  16  wrapping count of issued reads

## Operation
- Reset values: state=IDLE, wrreq=0, rdreq=0, level=0, stall_cnt=0, rd_total=0.
- Each edge samples S (state) and L (level) plus the inputs, then computes:
  - wr_d = Enwrk & ENgen & (S==PRIME | S==RUN) & (L<DEPTH)
  - rd_d = Enwrk & ENraf & (S==RUN | S==DRAIN) & (L>0)
- Registered updates on that edge:
  - wrreq<=wr_d, rdreq<=rd_d
  - level<=L+wr_d-rd_d; a simultaneous read and write leaves level unchanged
  - rd_total+=rd_d, wrapping
  - stall_cnt+1 when Enwrk & ENgen & S∈{PRIME,RUN} & L==DEPTH; saturates at 255
- Transitions use registered S and L. Priority is top-down; the first match wins.
  - Any state, !Enwrk → IDLE.
  - IDLE: ENgen → PRIME; else ENraf & L>0 → DRAIN; else stay.
  - PRIME: L>=HI_WM & ENraf → RUN; !ENgen & ENraf & L>0 → DRAIN; !ENgen & !ENraf → IDLE; else stay.
  - RUN: !ENgen & ENraf → DRAIN; !ENgen & !ENraf → IDLE; L<=LO_WM & ENgen → PRIME; else stay.
  - DRAIN: ENgen → PRIME; !ENraf | L==0 → IDLE; else stay.
- Full (L==DEPTH): wrreq is suppressed and stall_cnt counts. Empty (L==0): rdreq is suppressed. Neither strobe can drive the FIFO past its bounds.
- An asynchronous reset mid-operation clears everything immediately. The FIFO must be cleared by the same reset, otherwise level desynchronises.

## Timing
- Input-to-strobe latency: 1 cycle; strobes are registered.
- State-to-strobe latency: 1 cycle. The first PRIME write appears one cycle after entering PRIME.
- One-cycle decision lag on L: PRIME issues one more write on the edge it leaves for RUN. Reading therefore starts at level HI_WM+1.
- level is valid in the same cycle the corresponding strobe is high. The FIFO's own usedw lags level by the FIFO latency.

## Structure
- Package fifo_sched_pkg holds:
  - enum state_t {IDLE, PRIME, RUN, DRAIN} encoded 2 bits
  - default watermark/depth localparams
- Sub-module sat_cnt #(W) (enable, saturate at all-ones) is used for stall_cnt.
- Everything else stays in one always_ff plus one always_comb.

## Test plan
- Reset, then Enwrk=ENgen=ENraf=1 → state 0→1 after 1 edge; level ramps 1..13; state=RUN when level=13; level then holds at 13 with wrreq=rdreq=1 every cycle.
- ENgen=1, ENraf=0 for 25 cycles → level reaches 16, wrreq drops, stall_cnt increments once per cycle thereafter (≥7), state stays PRIME.
- From level 16, set ENgen=0, ENraf=1 → state DRAIN; exactly 16 rdreq pulses; level 0; then IDLE; rd_total=16; rdreq never high at level 0.
- In RUN, ENraf held with generator writes masked so level falls to 4 (LO_WM) while ENgen=1 → state returns to PRIME and rdreq stops until level ≥12 again.
- Drive stall condition 300 cycles → stall_cnt saturates at 255.
- Assert RST=0 mid-RUN for 1 ns (asynchronous, between edges) → wrreq, rdreq, level and the counters are 0 and state is IDLE immediately; after release, sequence 1 repeats identically.
